tt_pin_host: RTL
================

TT_PIN_HOST -- requirements
Module: tt_pin_host

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: io_cmd_data  in  8  command byte; io_cmd_valid  in  1; io_cmd_ready  out  1.
REQ-004 SHALL have ports: io_rsp_data  out  8  response byte; io_rsp_valid  out  1; io_rsp_ready  in  1.
REQ-005 SHALL have ports: io_ui_drive  out  8  drives the design-under-test (DUT) ui_in.
REQ-006 SHALL have ports: io_uio_drive  out  8  drives the DUT uio_in.
REQ-007 SHALL have ports: io_uo_sense  in  8  DUT uo_out; io_uio_sense  in  8  DUT uio_out; io_uio_oe_sense  in  8  DUT uio_oe.
REQ-008 SHALL have ports: io_dut_clk  out  1  stepped DUT clock; io_dut_rst_n  out  1  DUT reset, active low.

Function
REQ-009 SHALL accept a byte only on a cycle where io_cmd_valid and io_cmd_ready are both 1.
REQ-010 SHALL assert io_cmd_ready only in states IDLE and OPERAND.
REQ-011 SHALL implement states IDLE, OPERAND, STEP_HI, STEP_LO, RESP.
REQ-012 SHALL decode opcodes accepted in IDLE:
- 0x01 SET_UI, 0x02 SET_UIO, 0x05 STEP, 0x06 DUT_RST: latch opcode, go to OPERAND.
- 0x03 READ_UO, 0x04 READ_UIO: go to RESP.
- any other value: go to RESP.
REQ-013 SHALL, on operand accept, apply the operand as follows and then go to IDLE, with no response:
- SET_UI: io_ui_drive <= operand.
- SET_UIO: io_uio_drive <= operand.
- DUT_RST: io_dut_rst_n <= operand[0].
REQ-014 SHALL, on a STEP operand accept, load a 9-bit step counter with the operand (0x00 loads 256) and go to STEP_HI.
REQ-015 SHALL hold io_dut_clk=1 for exactly one cycle in STEP_HI, then io_dut_clk=0 for exactly one cycle in STEP_LO, decrementing the counter in STEP_LO.
REQ-016 SHALL, in STEP_LO, go to STEP_HI if the decremented count is nonzero, else go to RESP with response 0xA5.
REQ-017 SHALL make io_dut_clk a registered output, 0 outside STEP_HI.
REQ-018 SHALL, for READ_UO, load io_rsp_data with io_uo_sense as sampled at the opcode-accept edge.
REQ-019 SHALL, for READ_UIO, load io_rsp_data at the accept edge with (io_uio_sense AND io_uio_oe_sense) OR (io_uio_drive AND NOT io_uio_oe_sense), bitwise.
REQ-020 SHALL load io_rsp_data with 0xEE for an unknown opcode.
REQ-021 SHALL assert io_rsp_valid exactly while in RESP; latency from accept edge (or final STEP_LO edge) to io_rsp_valid=1 is one cycle.
REQ-022 SHALL hold io_rsp_data stable while io_rsp_valid=1 and io_rsp_ready=0.
REQ-023 SHALL leave RESP for IDLE on the edge where io_rsp_ready=1; the next command is accepted no earlier than the following cycle.
REQ-024 SHALL ignore io_cmd_valid in STEP_HI, STEP_LO and RESP; the bytes are not consumed.
REQ-025 SHALL leave io_ui_drive, io_uio_drive and io_dut_rst_n unchanged by READ, STEP and unknown commands.

Reset
REQ-026 SHALL, on reset=1 at a rising edge, set:
- state IDLE, io_cmd_ready=1, io_rsp_valid=0, io_rsp_data=0x00.
- io_ui_drive=0x00, io_uio_drive=0x00.
- io_dut_clk=0, io_dut_rst_n=0, step counter 0.
REQ-027 SHALL give reset priority over any handshake in the same cycle; a STEP or pending response is discarded mid-operation and io_dut_clk returns to 0 on that edge.

Verification
REQ-028 SHALL cover: bytes 0x01,0x3C then 0x03 with io_uo_sense=0x5A -> io_ui_drive=0x3C after the operand edge; io_rsp_data=0x5A, io_rsp_valid one cycle after the 0x03 accept.
REQ-029 SHALL cover: 0x05,0x03 -> exactly 3 io_dut_clk high pulses, each 1 cycle wide with 1 low cycle between; then response 0xA5; io_cmd_ready=0 throughout the step sequence.
REQ-030 SHALL cover: 0x05,0x00 -> 256 pulses, then 0xA5.
REQ-031 SHALL cover: 0x02,0xF0 then 0x04 with io_uio_oe_sense=0x0F, io_uio_sense=0x33 -> response 0xF3.
REQ-032 SHALL cover: 0x77 -> 0xEE. Holding io_rsp_ready=0 for 5 cycles keeps io_rsp_valid=1 and data stable; a following command is accepted only after the RESP exit.
REQ-033 SHALL cover: reset asserted during the 2nd pulse of STEP 4 -> io_dut_clk=0, state IDLE, no response; then 0x06,0x01 -> io_dut_rst_n=1.

Source files
------------

// File: rtl/tt_pin_host.sv
// tt_pin_host: byte-command host that drives and senses the pins
// of a Tiny Tapeout style DUT and single-steps its clock.
module tt_pin_host (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] io_cmd_data,
  input  logic       io_cmd_valid,
  output logic       io_cmd_ready,
  output logic [7:0] io_rsp_data,
  output logic       io_rsp_valid,
  input  logic       io_rsp_ready,
  output logic [7:0] io_ui_drive,
  output logic [7:0] io_uio_drive,
  input  logic [7:0] io_uo_sense,
  input  logic [7:0] io_uio_sense,
  input  logic [7:0] io_uio_oe_sense,
  output logic       io_dut_clk,
  output logic       io_dut_rst_n
);

  typedef enum logic [2:0] {
    IDLE,
    OPERAND,
    STEP_HI,
    STEP_LO,
    RESP
  } state_t;

  localparam logic [7:0] OP_SET_UI  = 8'h01;
  localparam logic [7:0] OP_SET_UIO = 8'h02;
  localparam logic [7:0] OP_RD_UO   = 8'h03;
  localparam logic [7:0] OP_RD_UIO  = 8'h04;
  localparam logic [7:0] OP_STEP    = 8'h05;
  localparam logic [7:0] OP_DUT_RST = 8'h06;

  state_t     state;
  logic [7:0] opcode;
  logic [8:0] count;
  logic [8:0] count_dec;
  logic       cmd_fire;
  logic       is_operand;
  logic       is_rd_uo;
  logic       is_rd_uio;
  logic [7:0] uio_read;

  assign io_cmd_ready = (state == IDLE) || (state == OPERAND);
  assign io_rsp_valid = (state == RESP);
  assign cmd_fire     = io_cmd_valid && io_cmd_ready;
  assign count_dec    = count - 9'd1;

  assign is_operand = (io_cmd_data == OP_SET_UI)
                   || (io_cmd_data == OP_SET_UIO)
                   || (io_cmd_data == OP_STEP)
                   || (io_cmd_data == OP_DUT_RST);
  assign is_rd_uo   = (io_cmd_data == OP_RD_UO);
  assign is_rd_uio  = (io_cmd_data == OP_RD_UIO);

  // bidir pins read back what the DUT drives, else what we drive
  assign uio_read = (io_uio_sense & io_uio_oe_sense)
                  | (io_uio_drive & ~io_uio_oe_sense);

  // command FSM with registered pin drives and stepped DUT clock
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      opcode       <= 8'h00;
      count        <= 9'd0;
      io_rsp_data  <= 8'h00;
      io_ui_drive  <= 8'h00;
      io_uio_drive <= 8'h00;
      io_dut_clk   <= 1'b0;
      io_dut_rst_n <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_fire) begin
            unique case (1'b1)
              is_operand: begin
                opcode <= io_cmd_data;
                state  <= OPERAND;
              end
              is_rd_uo: begin
                io_rsp_data <= io_uo_sense;
                state       <= RESP;
              end
              is_rd_uio: begin
                io_rsp_data <= uio_read;
                state       <= RESP;
              end
              default: begin
                io_rsp_data <= 8'hEE;
                state       <= RESP;
              end
            endcase
          end
        end
        OPERAND: begin
          if (cmd_fire) begin
            state <= IDLE;
            case (opcode)
              OP_SET_UI:  io_ui_drive  <= io_cmd_data;
              OP_SET_UIO: io_uio_drive <= io_cmd_data;
              OP_DUT_RST: io_dut_rst_n <= io_cmd_data[0];
              OP_STEP: begin
                count      <= (io_cmd_data == 8'h00) ? 9'd256
                                                     : {1'b0, io_cmd_data};
                io_dut_clk <= 1'b1;
                state      <= STEP_HI;
              end
              default: ;
            endcase
          end
        end
        STEP_HI: begin
          io_dut_clk <= 1'b0;
          state      <= STEP_LO;
        end
        STEP_LO: begin
          count <= count_dec;
          if (count_dec != 9'd0) begin
            io_dut_clk <= 1'b1;
            state      <= STEP_HI;
          end else begin
            io_rsp_data <= 8'hA5;
            state       <= RESP;
          end
        end
        RESP: begin
          if (io_rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
